// File: rtl/bit_test_pkg.sv
// bit_test_pkg: shared FSM state type and default pattern constants for the BIT path
package bit_test_pkg;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, DONE} state_t;
  localparam logic [7:0] DEFAULT_PATTERN = 8'h9A;
  localparam logic [31:0] DEFAULT_MAX_BYTES = 32'h4C4B400;
  localparam logic [7:0] TOGGLE_PATTERN = 8'hAA;
endpackage

// File: rtl/rx_bit_checker_popcount8.sv
// popcount8: number of set bits in a byte
module popcount8 (
  input  logic [7:0] d,
  output logic [3:0] cnt
);
  // sum the bits of d
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, d[i]};
  end
endmodule

// File: rtl/rx_bit_checker.sv
// rx_bit_checker: byte-aligns the serial BIT stream and counts bytes and bit errors; RX_TOGGLE_MODE_EN switches to the 0xAA/0x55 toggle pattern
module rx_bit_checker
  import bit_test_pkg::*;
#(
  parameter logic [7:0]  PATTERN    = DEFAULT_PATTERN,
  parameter logic [31:0] MAX_BYTES  = DEFAULT_MAX_BYTES,
  parameter int          LOCK_BYTES = 4,
  parameter int          LOSS_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit_data,
  output logic        locked,
  output logic        done,
  output logic        err_flag,
  output logic [31:0] byte_count,
  output logic [31:0] err_count
);
  state_t state;
  logic sync0, sync1, boundary, match, hunt_hit;
  logic [7:0] sr, sr_nx, exp_byte;
  logic [2:0] bit_cnt;
  logic [31:0] good_cnt, bad_cnt, err_sat;
  logic [32:0] err_sum;
  logic [3:0] errs;
  assign sr_nx = {sr[6:0], sync1};
  assign boundary = bit_cnt == 3'd7;
  assign match = sr_nx == exp_byte;
  assign err_sum = {1'b0, err_count} + {29'd0, errs};
  assign err_sat = err_sum[32] ? '1 : err_sum[31:0];
`ifdef RX_TOGGLE_MODE_EN
  logic [7:0] phase;
  assign hunt_hit = sr_nx == TOGGLE_PATTERN || sr_nx == ~TOGGLE_PATTERN;
  assign exp_byte = phase;
  // remember which toggle phase HUNT aligned to
  always_ff @(posedge clk)
    if (rst) phase <= TOGGLE_PATTERN;
    else if (state == HUNT && hunt_hit) phase <= sr_nx;
`else
  assign hunt_hit = match;
  assign exp_byte = PATTERN;
`endif
  popcount8 u_pc (.d(sr_nx ^ exp_byte), .cnt(errs));
  // input path, byte alignment FSM and result counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      sr <= '0;
      bit_cnt <= '0;
      good_cnt <= '0;
      bad_cnt <= '0;
      locked <= 1'b0;
      done <= 1'b0;
      err_flag <= 1'b0;
      byte_count <= '0;
      err_count <= '0;
    end else begin
      sync0 <= rx_bit_data;
      sync1 <= sync0;
      sr <= sr_nx;
      bit_cnt <= bit_cnt + 3'd1;
      case (state)
        HUNT:
          if (hunt_hit) begin
            bit_cnt <= '0;
            good_cnt <= 32'd1;
            state <= VERIFY;
          end
        VERIFY:
          if (boundary) begin
            if (!match) begin
              good_cnt <= '0;
              state <= HUNT;
            end else begin
              good_cnt <= good_cnt + 32'd1;
              if (good_cnt + 32'd1 == 32'(LOCK_BYTES)) begin
                bad_cnt <= '0;
                locked <= 1'b1;
                state <= LOCKED;
              end
            end
          end
        LOCKED:
          if (boundary) begin
            if (byte_count >= MAX_BYTES) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              byte_count <= byte_count + 32'd1;
              err_count <= err_sat;
              err_flag <= err_flag | (errs != 4'd0);
              bad_cnt <= errs != 4'd0 ? bad_cnt + 32'd1 : '0;
              if (byte_count + 32'd1 == MAX_BYTES) begin
                done <= 1'b1;
                state <= DONE;
              end else if (errs != 4'd0 && bad_cnt + 32'd1 == 32'(LOSS_BYTES)) begin
                locked <= 1'b0;
                good_cnt <= '0;
                state <= HUNT;
              end
            end
          end
        default: ;
      endcase
    end
  end
endmodule
